// File: rtl/spi_master.sv
// SPI master: serialises a {cmd, payload} request into an SS_n/MOSI frame and,
// for read-data commands, captures the slave's 8-bit MISO reply into rdata.
module spi_master #(
  parameter int TURNAROUND = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] cmd,
  input  logic [7:0] payload,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  localparam int TW = $clog2(TURNAROUND + 1);
  localparam logic [TW-1:0] TURN_LAST = TW'(TURNAROUND - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_TURN,
    S_CAPTURE,
    S_END
  } state_t;

  state_t          state;
  logic [9:0]      frame;
  logic [3:0]      bit_cnt;
  logic [TW-1:0]   turn_cnt;
  logic [7:0]      shreg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      frame    <= '0;
      bit_cnt  <= '0;
      turn_cnt <= '0;
      shreg    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rdata    <= 8'h00;
      SS_n     <= 1'b1;
      MOSI     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_SHIFT;
            frame   <= {cmd, payload};
            bit_cnt <= '0;
            SS_n    <= 1'b0;
            busy    <= 1'b1;
            MOSI    <= cmd[1];
          end
        end

        S_SHIFT: begin
          if (bit_cnt == 4'd10) begin
            MOSI    <= 1'b0;
            bit_cnt <= '0;
            if (frame[9:8] == 2'b11) begin
              // A one-cycle turnaround needs no counting: go straight to sampling.
              if (TURNAROUND == 1) begin
                state <= S_CAPTURE;
              end else begin
                state    <= S_TURN;
                turn_cnt <= TW'(1);
              end
            end else begin
              state <= S_END;
              SS_n  <= 1'b1;
              done  <= 1'b1;
            end
          end else begin
            MOSI    <= frame[4'd9 - bit_cnt];
            bit_cnt <= bit_cnt + 4'd1;
          end
        end

        S_TURN: begin
          if (turn_cnt == TURN_LAST) begin
            state <= S_CAPTURE;
          end else begin
            turn_cnt <= turn_cnt + 1'b1;
          end
        end

        S_CAPTURE: begin
          shreg   <= {shreg[6:0], MISO};
          bit_cnt <= bit_cnt + 4'd1;
          // The eighth sample goes straight into rdata along with the shifted bits.
          if (bit_cnt == 4'd7) begin
            state <= S_END;
            rdata <= {shreg[6:0], MISO};
            SS_n  <= 1'b1;
            done  <= 1'b1;
          end
        end

        S_END: begin
          state    <= S_IDLE;
          done     <= 1'b0;
          busy     <= 1'b0;
          bit_cnt  <= '0;
          turn_cnt <= '0;
          shreg    <= '0;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: write/read frames, ignored start, mid-frame reset,
// back-to-back launches and mid-frame input changes.
module tb_spi_master;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [1:0] cmd;
  logic [7:0] payload;
  logic       busy, done, SS_n, MOSI, MISO;
  logic [7:0] rdata;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;

  spi_master #(.TURNAROUND(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cmd(cmd), .payload(payload),
    .busy(busy), .done(done), .rdata(rdata), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents a request at a negedge; returns at the negedge following E0.
  task automatic launch(input logic [1:0] c, input logic [7:0] p);
    @(negedge clk);
    start = 1'b1; cmd = c; payload = p;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Checks MOSI after E0..E10; optional start pulse / input change at step k.
  task automatic check_shift(input string tag, input logic [10:0] exp,
                             input int ign_at, input int chg_at);
    for (int k = 0; k <= 10; k++) begin
      chk({tag, "_mosi"}, MOSI, exp[10-k]);
      chk({tag, "_ssn"}, SS_n, 1'b0);
      if (k == 0) chk({tag, "_busy"}, busy, 1'b1);
      if (k == ign_at) begin start = 1'b1; cmd = 2'b01; payload = 8'hC3; end
      if (k == chg_at) begin cmd = ~cmd; payload = ~payload; end
      if (k < 10) @(negedge clk);
      if (k == ign_at) start = 1'b0;
    end
  endtask

  task automatic end_write(input string tag);
    @(negedge clk);
    chk({tag, "_end_ssn"}, SS_n, 1'b1);
    chk({tag, "_end_done"}, done, 1'b1);
    chk({tag, "_end_busy"}, busy, 1'b1);
    chk({tag, "_end_mosi"}, MOSI, 1'b0);
    @(negedge clk);
    chk({tag, "_idle_done"}, done, 1'b0);
    chk({tag, "_idle_busy"}, busy, 1'b0);
    chk({tag, "_idle_ssn"}, SS_n, 1'b1);
  endtask

  initial begin
    int d0;
    logic [7:0] rbyte;
    rst_n = 1'b0; start = 1'b0; cmd = 2'b00; payload = 8'h00; MISO = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ssn", SS_n, 1'b1);
    chk("rst_mosi", MOSI, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_rdata", rdata, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);

    // Write-addr 0x3A
    d0 = done_cnt;
    launch(2'b00, 8'h3A);
    check_shift("wa3a", 11'b0_00_00111010, -1, -1);
    end_write("wa3a");
    chk("wa3a_rdata", rdata, 8'h00);
    chk("wa3a_donecnt", done_cnt - d0, 1);

    // Read-data, slave returns 0xA5 sampled at E13..E20
    rbyte = 8'hA5;
    launch(2'b11, 8'h00);
    check_shift("rd", 11'b1_11_00000000, -1, -1);
    @(negedge clk);
    chk("rd_turn1_ssn", SS_n, 1'b0);
    chk("rd_turn1_mosi", MOSI, 1'b0);
    @(negedge clk);
    chk("rd_turn2_ssn", SS_n, 1'b0);
    chk("rd_turn2_done", done, 1'b0);
    for (int i = 0; i < 8; i++) begin
      MISO = rbyte[7-i];
      @(negedge clk);
      if (i < 7) begin
        chk("rd_cap_ssn", SS_n, 1'b0);
        chk("rd_cap_done", done, 1'b0);
        chk("rd_cap_rdata", rdata, 8'h00);
      end
    end
    chk("rd_end_done", done, 1'b1);
    chk("rd_end_ssn", SS_n, 1'b1);
    chk("rd_end_rdata", rdata, 8'hA5);
    chk("rd_end_busy", busy, 1'b1);
    MISO = 1'b0;
    @(negedge clk);
    chk("rd_idle_busy", busy, 1'b0);
    chk("rd_idle_done", done, 1'b0);

    // Ignored start mid-frame, then write-data 0xFF
    d0 = done_cnt;
    launch(2'b00, 8'h55);
    check_shift("ign", 11'b0_00_01010101, 5, -1);
    end_write("ign");
    repeat (4) @(negedge clk);
    chk("ign_ssn_after", SS_n, 1'b1);
    chk("ign_busy_after", busy, 1'b0);
    chk("ign_donecnt", done_cnt - d0, 1);
    chk("ign_rdata_kept", rdata, 8'hA5);
    launch(2'b01, 8'hFF);
    check_shift("wdff", 11'b0_01_11111111, -1, -1);
    end_write("wdff");
    chk("wdff_rdata_kept", rdata, 8'hA5);

    // Reset mid read-data frame, between E6 and E7
    d0 = done_cnt;
    launch(2'b11, 8'h5A);
    repeat (6) @(negedge clk);
    chk("rst_mid_ssn_pre", SS_n, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_ssn", SS_n, 1'b1);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_done", done, 1'b0);
    chk("rst_mid_rdata", rdata, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_mid_donecnt", done_cnt - d0, 0);
    launch(2'b00, 8'hC6);
    check_shift("postrst", 11'b0_00_11000110, -1, -1);
    end_write("postrst");

    // Back-to-back write-addr 0x01 then 0x02, start held high
    @(negedge clk);
    start = 1'b1; cmd = 2'b00; payload = 8'h01;
    @(posedge clk);
    @(negedge clk);
    payload = 8'h02;
    check_shift("b2b1", 11'b0_00_00000001, -1, -1);
    @(negedge clk);
    chk("b2b_gap1_ssn", SS_n, 1'b1);
    chk("b2b_gap1_done", done, 1'b1);
    @(negedge clk);
    chk("b2b_gap2_ssn", SS_n, 1'b1);
    chk("b2b_gap2_busy", busy, 1'b0);
    @(negedge clk);
    start = 1'b0;
    check_shift("b2b2", 11'b0_00_00000010, -1, -1);
    end_write("b2b2");

    // Read-addr 0x96 with cmd/payload inverted after E3
    launch(2'b10, 8'h96);
    check_shift("chg", 11'b1_10_10010110, -1, 3);
    end_write("chg");
    chk("chg_rdata", rdata, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
